// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: sole Wishbone master of the PID register file.
// After reset it writes KP/KI/KD/SP (indices 0..3). Each accepted process
// sample then runs one loop step: write pv (index 4), read un (index 8),
// read of (index 10), and publish un >>> U_SHIFT saturated to 16 bits.
// Setpoint strobes are parked in a pending register and written from IDLE.
//
// Ports:
//   clk, rst (async assert, active-low)
//   i_pv/i_pv_valid/o_pv_ready  : process-variable sample handshake
//   i_sp/i_sp_valid             : setpoint update strobe
//   o_wb_* / i_wb_*             : Wishbone classic master port
//   o_u/o_u_valid               : actuator command and update pulse
//   o_of                        : last overflow flags read
//   o_err                       : sticky bus-timeout flag
//
// Build option: define PID_SEQ_WDT_EN to enable the ack watchdog
// (WDT_CYCLES clocks). Without it the FSM waits forever and o_err is 0.
module pid_loop_sequencer #(
  parameter logic [15:0] KP_INIT    = 16'h0080,
  parameter logic [15:0] KI_INIT    = 16'h0005,
  parameter logic [15:0] KD_INIT    = 16'h0005,
  parameter logic [15:0] SP_INIT    = 16'h0F87,
  parameter int unsigned U_SHIFT    = 8,
  parameter int unsigned WDT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_pv,
  input  logic        i_pv_valid,
  output logic        o_pv_ready,
  input  logic [15:0] i_sp,
  input  logic        i_sp_valid,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic [15:0] o_u,
  output logic        o_u_valid,
  output logic [4:0]  o_of,
  output logic        o_err
);

  localparam logic [15:0] ADR_KP = 16'(0 * 4);
  localparam logic [15:0] ADR_KI = 16'(1 * 4);
  localparam logic [15:0] ADR_KD = 16'(2 * 4);
  localparam logic [15:0] ADR_SP = 16'(3 * 4);
  localparam logic [15:0] ADR_PV = 16'(4 * 4);
  localparam logic [15:0] ADR_UN = 16'(8 * 4);
  localparam logic [15:0] ADR_OF = 16'(10 * 4);

  typedef enum logic [3:0] {
    INIT_KP, INIT_KI, INIT_KD, INIT_SP, IDLE,
    WR_SP, WR_PV, RD_UN, RD_OF, OUT
  } state_t;

  state_t      state, state_d;
  logic        sp_pend, sp_pend_d;
  logic [15:0] sp_val, sp_val_d;
  logic [15:0] pv_q, pv_d;
  logic [31:0] un_q, un_d;
  logic        cyc_d, stb_d, we_d, ready_d, u_valid_d;
  logic [15:0] adr_d, u_d;
  logic [31:0] data_d;
  logic [4:0]  of_d;
  logic        req_valid, req_we;
  logic [15:0] req_adr;
  logic [31:0] req_data;
  logic        xfer_done_c, timeout_c, xfer_end_c, accept_c;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Arithmetic shift of the 32-bit core output, clamped to int16.
  function automatic logic [15:0] sat_u(input logic [31:0] un);
    logic signed [31:0] t;
    t = $signed(un) >>> U_SHIFT;
    if (t > 32'sd32767)       return 16'h7FFF;
    else if (t < -32'sd32768) return 16'h8000;
    else                      return t[15:0];
  endfunction

  // An ack only counts while a cycle is open.
  assign xfer_done_c = o_wb_cyc & i_wb_ack;
  assign xfer_end_c  = xfer_done_c | timeout_c;
  assign accept_c    = (state == IDLE) & ~sp_pend & i_pv_valid & o_pv_ready;

`ifdef PID_SEQ_WDT_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_cnt;
  logic             err_q;

  assign timeout_c = o_wb_cyc & ~i_wb_ack & (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  assign o_err     = err_q;

  // Counts clocks of the open cycle; restarts whenever the bus is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      wdt_cnt <= o_wb_cyc ? wdt_cnt + 1'b1 : '0;
      if (timeout_c) err_q <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign o_err     = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT_KP;
      sp_pend    <= 1'b0;
      sp_val     <= '0;
      pv_q       <= '0;
      un_q       <= '0;
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_adr   <= '0;
      o_wb_data  <= '0;
      o_pv_ready <= 1'b0;
      o_u        <= '0;
      o_u_valid  <= 1'b0;
      o_of       <= '0;
    end else begin
      state      <= state_d;
      sp_pend    <= sp_pend_d;
      sp_val     <= sp_val_d;
      pv_q       <= pv_d;
      un_q       <= un_d;
      o_wb_cyc   <= cyc_d;
      o_wb_stb   <= stb_d;
      o_wb_we    <= we_d;
      o_wb_adr   <= adr_d;
      o_wb_data  <= data_d;
      o_pv_ready <= ready_d;
      o_u        <= u_d;
      o_u_valid  <= u_valid_d;
      o_of       <= of_d;
    end
  end

  // Next state: bus states advance when their transfer ends.
  always_comb begin
    state_d = state;
    unique case (state)
      INIT_KP: if (xfer_end_c) state_d = INIT_KI;
      INIT_KI: if (xfer_end_c) state_d = INIT_KD;
      INIT_KD: if (xfer_end_c) state_d = INIT_SP;
      INIT_SP: if (xfer_end_c) state_d = IDLE;
      IDLE: begin
        if (sp_pend)       state_d = WR_SP;
        else if (accept_c) state_d = WR_PV;
      end
      WR_SP:   if (xfer_end_c)  state_d = IDLE;
      WR_PV:   if (xfer_done_c) state_d = RD_UN; else if (timeout_c) state_d = IDLE;
      RD_UN:   if (xfer_done_c) state_d = RD_OF; else if (timeout_c) state_d = IDLE;
      RD_OF:   if (xfer_done_c) state_d = OUT;   else if (timeout_c) state_d = IDLE;
      OUT:     state_d = IDLE;
      default: state_d = INIT_KP;
    endcase
  end

  // Output/datapath next values.
  always_comb begin
    cyc_d     = o_wb_cyc;
    stb_d     = o_wb_stb;
    we_d      = o_wb_we;
    adr_d     = o_wb_adr;
    data_d    = o_wb_data;
    u_d       = o_u;
    u_valid_d = 1'b0;
    of_d      = o_of;
    sp_pend_d = sp_pend;
    sp_val_d  = sp_val;
    pv_d      = pv_q;
    un_d      = un_q;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_data  = '0;

    unique case (state)
      INIT_KP: begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_KP; req_data = sext16(KP_INIT); end
      INIT_KI: begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_KI; req_data = sext16(KI_INIT); end
      INIT_KD: begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_KD; req_data = sext16(KD_INIT); end
      INIT_SP: begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_SP; req_data = sext16(SP_INIT); end
      WR_SP:   begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_SP; req_data = sext16(sp_val); end
      WR_PV:   begin req_valid = 1'b1; req_we = 1'b1; req_adr = ADR_PV; req_data = sext16(pv_q); end
      RD_UN:   begin req_valid = 1'b1; req_adr = ADR_UN; end
      RD_OF:   begin req_valid = 1'b1; req_adr = ADR_OF; end
      default: ;
    endcase

    // Open a transfer on entry to a bus state; close it on ack or timeout.
    // The state always moves on at the close, leaving one idle bus cycle.
    if (req_valid && !o_wb_cyc) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      we_d   = req_we;
      adr_d  = req_adr;
      data_d = req_data;
    end else if (xfer_end_c) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
    end

    if (accept_c)                        pv_d = i_pv;
    if (state == RD_UN && xfer_done_c)   un_d = i_wb_data;
    if (state == RD_OF && xfer_done_c)   of_d = i_wb_data[4:0];
    if (state == OUT) begin
      u_d       = sat_u(un_q);
      u_valid_d = 1'b1;
    end

    // A strobe landing on the WR_SP ack keeps the newer value pending.
    if (state == WR_SP && xfer_done_c) sp_pend_d = 1'b0;
    if (i_sp_valid) begin
      sp_pend_d = 1'b1;
      sp_val_d  = i_sp;
    end

    // Ready only after a full cycle settled in IDLE with nothing pending.
    ready_d = (state == IDLE) && (state_d == IDLE) && !sp_pend_d;
  end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
module tb_pid_loop_sequencer;

  localparam int unsigned U_SHIFT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_pv;
  logic        i_pv_valid;
  logic        o_pv_ready;
  logic [15:0] i_sp;
  logic        i_sp_valid;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [15:0] o_wb_adr;
  logic [31:0] o_wb_data;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
  logic [15:0] o_u;
  logic        o_u_valid;
  logic [4:0]  o_of;
  logic        o_err;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [31:0] data;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [31:0] slave_un = '0;
  logic [31:0] slave_of = '0;
  logic        stall_un = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  pid_loop_sequencer dut (
    .clk(clk), .rst(rst),
    .i_pv(i_pv), .i_pv_valid(i_pv_valid), .o_pv_ready(o_pv_ready),
    .i_sp(i_sp), .i_sp_valid(i_sp_valid),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_u(o_u), .o_u_valid(o_u_valid), .o_of(o_of), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Zero-wait-state stub slave: ack seen at the first edge after stb.
  always_comb begin
    i_wb_ack = o_wb_cyc & o_wb_stb & ~(stall_un & (o_wb_adr == 16'h0020));
    case (o_wb_adr)
      16'h0020: i_wb_data = slave_un;
      16'h0028: i_wb_data = slave_of;
      default:  i_wb_data = 32'h0;
    endcase
  end

  // Record every completed bus transfer.
  always @(negedge clk)
    if (rst && o_wb_cyc && o_wb_stb && i_wb_ack)
      obs_q.push_back('{we: o_wb_we, adr: o_wb_adr, data: o_wb_data});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: floor(un / 2^U_SHIFT), clamped to int16.
  function automatic logic [15:0] model_u(input logic [31:0] un);
    longint s, d, t;
    s = longint'($signed(un));
    d = longint'(1) << U_SHIFT;
    t = (s >= 0) ? s / d : -((-s + d - 1) / d);
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t);
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return 32'(longint'($signed(v)));
  endfunction

  task automatic expect_txn(input logic we, input logic [15:0] adr, input logic [31:0] data);
    exp_q.push_back('{we: we, adr: adr, data: data});
  endtask

  task automatic check_txns(input string tag);
    int n;
    check({tag, "_ntxn"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_we"},  32'(obs_q[i].we),  32'(exp_q[i].we));
      check({tag, "_adr"}, 32'(obs_q[i].adr), 32'(exp_q[i].adr));
      if (exp_q[i].we) check({tag, "_wdata"}, obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ready(input string tag);
    int c = 0;
    while (!o_pv_ready && c < 100) begin
      @(posedge clk); @(negedge clk);
      c++;
    end
    check(tag, 32'(o_pv_ready), 32'd1);
  endtask

  // Release reset and check the init writes and ready latency.
  task automatic run_init();
    int c = 0;
    bit seen = 1'b0;
    obs_q.delete();
    exp_q.delete();
    expect_txn(1'b1, 16'h0000, 32'h0000_0080);
    expect_txn(1'b1, 16'h0004, 32'h0000_0005);
    expect_txn(1'b1, 16'h0008, 32'h0000_0005);
    expect_txn(1'b1, 16'h000C, 32'h0000_0F87);
    @(negedge clk);
    rst = 1'b1;
    while (c < 40 && !seen) begin
      @(posedge clk); @(negedge clk);
      c++;
      seen = o_pv_ready;
    end
    check("init_ready_latency", 32'(c), 32'd9);
    check_txns("init");
  endtask

  // One loop step; optionally strobe two setpoints while it runs.
  task automatic run_step(input logic [15:0] pv, input logic [31:0] un,
                          input logic [31:0] ofw, input bit sp_inj);
    int          pulses = 0;
    bit          back = 1'b0;
    logic [15:0] u_seen = '0;
    slave_un = un;
    slave_of = ofw;
    wait_ready("step_ready");
    i_pv = pv;
    i_pv_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    i_pv_valid = 1'b0;
    i_pv = 16'($urandom);
    expect_txn(1'b1, 16'h0010, sx(pv));
    expect_txn(1'b0, 16'h0020, 32'h0);
    expect_txn(1'b0, 16'h0028, 32'h0);
    if (sp_inj) expect_txn(1'b1, 16'h000C, 32'h0000_0200);
    for (int c = 0; c < 60 && !back; c++) begin
      i_sp_valid = 1'b0;
      if (sp_inj && c == 1) begin i_sp = 16'h0100; i_sp_valid = 1'b1; end
      if (sp_inj && c == 3) begin i_sp = 16'h0200; i_sp_valid = 1'b1; end
      @(posedge clk); @(negedge clk);
      if (o_u_valid) begin pulses++; u_seen = o_u; end
      back = o_pv_ready;
    end
    i_sp_valid = 1'b0;
    check("step_ready_back", 32'(back), 32'd1);
    check("u_valid_pulses", 32'(pulses), 32'd1);
    check("o_u", 32'(u_seen), 32'(model_u(un)));
    check("o_of", 32'(o_of), 32'(ofw[4:0]));
    check_txns(sp_inj ? "sp_step" : "step");
  endtask

  initial begin
    logic [31:0] r, un;
    logic [15:0] fb;
    int c;
    rst = 1'b0;
    i_pv = '0; i_pv_valid = 1'b0; i_sp = '0; i_sp_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(o_pv_ready), 32'd0);
    check("rst_bus", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
    check("rst_adr", 32'(o_wb_adr), 32'd0);
    check("rst_wdata", o_wb_data, 32'd0);
    check("rst_out", {10'd0, o_u, o_u_valid, o_of}, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);

    run_init();

    run_step(16'h0000, 32'h0008_5EC6, 32'h0, 1'b0);
    check("u_pv0", 32'(o_u), 32'h0000_085E);

    fb = o_u;
    for (int i = 0; i < 10; i++) begin
      r = $urandom;
      un = (i % 3 == 0) ? r : {{8{r[23]}}, r[23:0]};
      run_step(fb, un, $urandom, 1'b0);
      fb = o_u;
    end

    run_step(16'h0100, 32'h7FFF_0000, 32'h1F, 1'b0);
    check("sat_pos", 32'(o_u), 32'h0000_7FFF);
    run_step(16'hFF00, 32'h8000_0000, 32'h0A, 1'b0);
    check("sat_neg", 32'(o_u), 32'h0000_8000);

    run_step(16'h1234, 32'h0001_2345, 32'h3, 1'b1);

    // Reset during an open cycle must drop cyc/stb immediately.
    wait_ready("rst_mid_ready");
    i_pv = 16'h0042;
    i_pv_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    i_pv_valid = 1'b0;
    c = 0;
    while (!o_wb_cyc && c < 20) begin @(posedge clk); @(negedge clk); c++; end
    check("rst_mid_cyc_open", 32'(o_wb_cyc), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_cyc_drop", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    run_init();
    run_step(16'h0007, 32'hFFFF_F000, 32'h11, 1'b0);

`ifdef PID_SEQ_WDT_EN
    begin
      int  hi = 0, pulses = 0;
      bit  back = 1'b0;
      stall_un = 1'b1;
      wait_ready("wdt_ready");
      i_pv = 16'h0005;
      i_pv_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      i_pv_valid = 1'b0;
      for (int k = 0; k < 300 && !back; k++) begin
        @(posedge clk); @(negedge clk);
        if (o_u_valid) pulses++;
        if (o_wb_cyc && o_wb_adr == 16'h0020) hi++;
        back = o_pv_ready;
      end
      stall_un = 1'b0;
      check("wdt_cyc_len", 32'(hi), 32'd64);
      check("wdt_err", 32'(o_err), 32'd1);
      check("wdt_no_u_valid", 32'(pulses), 32'd0);
      check("wdt_back_idle", 32'(back), 32'd1);
      obs_q.delete();
      exp_q.delete();
    end
`else
    check("err_tied_low", 32'(o_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
